dm_sba_serv: RTL and testbench
==============================

DM_SBA_SERV -- requirements
Module: dm_sba_serv

Interface
REQ-001 Parameter BusWidth, default 32, system-bus data/address width; legal values 32 and 64.
REQ-002 clk_i  in  1  single clock, all state on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 dmactive_i  in  1  debug module active; low aborts and idles the block.
REQ-005 sbaddress_i  in  BusWidth  new sbaddress value from DMI.
REQ-006 sbaddress_write_valid_i  in  1  one-cycle strobe, sbaddress_i written.
REQ-007 sbreadonaddr_i  in  1  sbcs.sbreadonaddr.
REQ-008 sbautoincrement_i  in  1  sbcs.sbautoincrement.
REQ-009 sbaccess_i  in  3  sbcs.sbaccess, access size 2^sbaccess bytes.
REQ-010 sbreadondata_i  in  1  sbcs.sbreadondata.
REQ-011 sbdata_i  in  BusWidth  write data from DMI.
REQ-012 sbdata_write_valid_i  in  1  one-cycle strobe, sbdata0 written.
REQ-013 sbdata_read_valid_i  in  1  one-cycle strobe, sbdata0 read.
REQ-014 sbaddress_o  out  BusWidth  current system-bus address.
REQ-015 sbdata_o  out  BusWidth  last read data, right-aligned, zero-extended.
REQ-016 sbdata_valid_o  out  1  one-cycle pulse, sbdata_o updated.
REQ-017 sbbusy_o  out  1  access in progress.
REQ-018 sberror_valid_o  out  1  one-cycle pulse, sberror_o valid.
REQ-019 sberror_o  out  3  error code per debug spec 0.13.
REQ-020 master_req_o  out  1  bus request.
REQ-021 master_add_o  out  BusWidth  bus address, BusWidth/8-aligned.
REQ-022 master_we_o  out  1  1 write, 0 read.
REQ-023 master_wdata_o  out  BusWidth  write data, lane-aligned.
REQ-024 master_be_o  out  BusWidth/8  byte enables.
REQ-025 master_gnt_i  in  1  request accepted.
REQ-026 master_r_valid_i  in  1  response valid.
REQ-027 master_r_rdata_i  in  BusWidth  read data.
REQ-028 master_r_err_i  in  1  response error, qualified by master_r_valid_i.

Function
REQ-029 FSM states Idle, Read, Write, WaitRead, WaitWrite; sbbusy_o = (state != Idle).
REQ-030 Idle triggers, priority high to low: sbdata_write_valid_i -> Write; sbaddress_write_valid_i with sbreadonaddr_i -> Read; sbdata_read_valid_i with sbreadondata_i -> Read.
REQ-031 sbaddress_write_valid_i loads sbaddress_o in any state; a load while busy does not affect the access in flight, which uses the address latched at trigger.
REQ-032 Other strobes while busy are ignored (no state change; sbbusyerror is owned by the CSR block).
REQ-033 Trigger with sbaccess_i > 2 (BusWidth 32) or > 3 (BusWidth 64): no request, sberror_o=4, sberror_valid_o pulse, stay Idle.
REQ-034 Trigger with address not aligned to 2^sbaccess: no request, sberror_o=3, pulse, stay Idle.
REQ-035 Read/Write: master_req_o=1 with add/we/wdata/be held stable until master_gnt_i; on gnt go to WaitRead/WaitWrite, master_req_o=0 next cycle.
REQ-036 master_add_o = address with low log2(BusWidth/8) bits zeroed; master_be_o = (2^(2^sbaccess)-1) << offset; master_wdata_o = sbdata_i << (8*offset).
REQ-037 WaitRead on master_r_valid_i: sbdata_o = (rdata >> 8*offset) masked to access size, sbdata_valid_o pulse next cycle, go Idle.
REQ-038 WaitWrite on master_r_valid_i: go Idle.
REQ-039 master_r_err_i with r_valid: sberror_o=2, pulse, no sbdata update, no autoincrement.
REQ-040 Error-free completion with sbautoincrement_i: sbaddress_o += 2^sbaccess, modulo 2^BusWidth.
REQ-041 Minimum read latency: trigger cycle T, req at T+1, gnt T+1, r_valid T+2, sbdata_valid_o at T+3.
REQ-042 dmactive_i low: next edge state=Idle, master_req_o=0, sbaddress_o=0; responses arriving in Idle ignored.

Reset
REQ-043 rst_i: state Idle; sbaddress_o, sbdata_o, sberror_o, master_* outputs 0; all pulses 0.

Structure
REQ-044 Package dm_serv gains SbErr codes (None 0, Timeout 1, BadAddr 2, Align 3, Size 4, Other 7) alongside existing sba_state_e; BusWidth stays a module parameter.
REQ-045 One combinational sub-module dm_sba_align_serv: byte-enable, write-shift and read-extract generation.

Verification
REQ-046 BusWidth=32, address 0x1002, sbaccess=1, write 0xBEEF -> be=0xC, wdata=0xBEEF0000, add=0x1000.
REQ-047 BusWidth=64, readonaddr, address 0x2004, sbaccess=2, rdata 0x11223344_55667788 -> sbdata_o=0x11223344 at T+3.
REQ-048 Readondata + autoincrement, sbaccess=2, four reads from 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-049 Address 0x1001, sbaccess=2 -> sberror_o=3, no master_req_o; sbaccess=3 at BusWidth 32 -> sberror_o=4.
REQ-050 gnt withheld 5 cycles, dmactive_i dropped in cycle 3 -> master_req_o low next cycle, Idle, later r_valid ignored.
REQ-051 Read with master_r_err_i -> sberror_o=2, sbdata_o unchanged, sbaddress_o not incremented.

Source files
------------

// File: rtl/dm_serv_pkg.sv
// Shared types for the debug-module system-bus access block.
package dm_serv;

    // System-bus access FSM states.
    typedef enum logic [2:0] {
        SbaIdle      = 3'd0,
        SbaRead      = 3'd1,
        SbaWrite     = 3'd2,
        SbaWaitRead  = 3'd3,
        SbaWaitWrite = 3'd4
    } sba_state_e;

    // sbcs.sberror codes.
    typedef enum logic [2:0] {
        SbErrNone    = 3'd0,
        SbErrTimeout = 3'd1,
        SbErrBadAddr = 3'd2,
        SbErrAlign   = 3'd3,
        SbErrSize    = 3'd4,
        SbErrOther   = 3'd7
    } sb_err_e;

    // Low address bits that must be zero for an access of 2^access bytes.
    function automatic logic [2:0] sb_align_mask(input logic [2:0] access);
        logic [2:0] mask;
        case (access)
            3'd0:    mask = 3'b000;
            3'd1:    mask = 3'b001;
            3'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dm_sba_align_serv.sv
// Byte-lane steering for system-bus accesses: byte enables, write-data
// shift into the addressed lanes, and read-data extraction back to bit 0.
module dm_sba_align_serv #(
    parameter  int unsigned BusWidth = 32,
    localparam int unsigned NumBytes = BusWidth / 8,
    localparam int unsigned OffW     = $clog2(NumBytes)
) (
    input  logic [OffW-1:0]     offset_i,
    input  logic [2:0]          access_i,
    input  logic [BusWidth-1:0] wdata_i,
    input  logic [BusWidth-1:0] rdata_i,
    output logic [NumBytes-1:0] be_o,
    output logic [BusWidth-1:0] wdata_o,
    output logic [BusWidth-1:0] rdata_o
);

    logic [NumBytes-1:0] be_base;
    logic [BusWidth-1:0] size_mask;

    // Unshifted byte-enable pattern and data mask for the access size.
    // Oversized accesses never reach the bus, so the default only needs to be benign.
    always_comb begin
        be_base   = '0;
        size_mask = '0;
        case (access_i)
            3'd0: begin
                be_base   = NumBytes'(8'h01);
                size_mask = BusWidth'(64'h0000_0000_0000_00FF);
            end
            3'd1: begin
                be_base   = NumBytes'(8'h03);
                size_mask = BusWidth'(64'h0000_0000_0000_FFFF);
            end
            3'd2: begin
                be_base   = NumBytes'(8'h0F);
                size_mask = BusWidth'(64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                be_base   = NumBytes'(8'hFF);
                size_mask = '1;
            end
        endcase
    end

    assign be_o    = be_base << offset_i;
    assign wdata_o = wdata_i << {offset_i, 3'b000};
    assign rdata_o = (rdata_i >> {offset_i, 3'b000}) & size_mask;

endmodule

// File: rtl/dm_sba_serv.sv
// System-bus access engine of the debug module.
//
// state        | meaning
// -------------+------------------------------------------------
// SbaIdle      | no access; waiting for a DMI trigger
// SbaRead      | read request on the bus, waiting for grant
// SbaWrite     | write request on the bus, waiting for grant
// SbaWaitRead  | read granted, waiting for response
// SbaWaitWrite | write granted, waiting for response
module dm_sba_serv
    import dm_serv::*;
#(
    parameter int unsigned BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sbdata_read_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic                  master_r_err_i
);

    localparam int unsigned NumBytes  = BusWidth / 8;
    localparam int unsigned OffW      = $clog2(NumBytes);
    localparam logic [2:0]  MaxAccess = (BusWidth == 64) ? 3'd3 : 3'd2;

    sba_state_e          state_q, state_d;
    logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
    logic [BusWidth-1:0] acc_addr_q, acc_addr_d;
    logic [2:0]          acc_size_q, acc_size_d;
    logic [BusWidth-1:0] wdata_q, wdata_d;
    logic [BusWidth-1:0] sbdata_q, sbdata_d;
    logic                sbdata_valid_q, sbdata_valid_d;
    sb_err_e             sberror_q, sberror_d;
    logic                sberror_valid_q, sberror_valid_d;

    logic                trig_write, trig_roa, trig_rod, trig_any;
    logic [BusWidth-1:0] trig_addr;
    logic                size_bad, align_bad;
    logic [NumBytes-1:0] al_be;
    logic [BusWidth-1:0] al_wdata, al_rdata;

    // Trigger decode; read-on-address uses the address being written this cycle.
    always_comb begin
        trig_write = sbdata_write_valid_i;
        trig_roa   = sbaddress_write_valid_i & sbreadonaddr_i;
        trig_rod   = sbdata_read_valid_i & sbreadondata_i;
        trig_any   = dmactive_i && (state_q == SbaIdle) && (trig_write || trig_roa || trig_rod);
        trig_addr  = (!trig_write && trig_roa) ? sbaddress_i : sbaddress_q;
        size_bad   = sbaccess_i > MaxAccess;
        align_bad  = (trig_addr[2:0] & sb_align_mask(sbaccess_i)) != 3'b000;
    end

    dm_sba_align_serv #(
        .BusWidth (BusWidth)
    ) u_align (
        .offset_i (acc_addr_q[OffW-1:0]),
        .access_i (acc_size_q),
        .wdata_i  (wdata_q),
        .rdata_i  (master_r_rdata_i),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata)
    );

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= SbaIdle;
            sbaddress_q     <= '0;
            acc_addr_q      <= '0;
            acc_size_q      <= '0;
            wdata_q         <= '0;
            sbdata_q        <= '0;
            sbdata_valid_q  <= 1'b0;
            sberror_q       <= SbErrNone;
            sberror_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sbaddress_q     <= sbaddress_d;
            acc_addr_q      <= acc_addr_d;
            acc_size_q      <= acc_size_d;
            wdata_q         <= wdata_d;
            sbdata_q        <= sbdata_d;
            sbdata_valid_q  <= sbdata_valid_d;
            sberror_q       <= sberror_d;
            sberror_valid_q <= sberror_valid_d;
        end
    end

    // Next-state logic; dropping dmactive forces Idle from anywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SbaIdle: begin
                if (trig_any && !size_bad && !align_bad) begin
                    state_d = trig_write ? SbaWrite : SbaRead;
                end
            end
            SbaRead:      if (master_gnt_i)     state_d = SbaWaitRead;
            SbaWrite:     if (master_gnt_i)     state_d = SbaWaitWrite;
            SbaWaitRead:  if (master_r_valid_i) state_d = SbaIdle;
            SbaWaitWrite: if (master_r_valid_i) state_d = SbaIdle;
            default:                            state_d = SbaIdle;
        endcase
        if (!dmactive_i) begin
            state_d = SbaIdle;
        end
    end

    // Datapath: address load, access latch, completion, error reporting.
    // Autoincrement steps from the address actually accessed; a DMI address
    // write in the completion cycle takes precedence.
    always_comb begin
        sbaddress_d     = sbaddress_q;
        acc_addr_d      = acc_addr_q;
        acc_size_d      = acc_size_q;
        wdata_d         = wdata_q;
        sbdata_d        = sbdata_q;
        sbdata_valid_d  = 1'b0;
        sberror_d       = sberror_q;
        sberror_valid_d = 1'b0;

        if (trig_any) begin
            if (size_bad) begin
                sberror_d       = SbErrSize;
                sberror_valid_d = 1'b1;
            end else if (align_bad) begin
                sberror_d       = SbErrAlign;
                sberror_valid_d = 1'b1;
            end else begin
                acc_addr_d = trig_addr;
                acc_size_d = sbaccess_i;
                if (trig_write) begin
                    wdata_d = sbdata_i;
                end
            end
        end

        if ((state_q == SbaWaitRead || state_q == SbaWaitWrite) && master_r_valid_i) begin
            if (master_r_err_i) begin
                sberror_d       = SbErrBadAddr;
                sberror_valid_d = 1'b1;
            end else begin
                if (state_q == SbaWaitRead) begin
                    sbdata_d       = al_rdata;
                    sbdata_valid_d = 1'b1;
                end
                if (sbautoincrement_i) begin
                    sbaddress_d = acc_addr_q + (BusWidth'(1) << acc_size_q);
                end
            end
        end

        if (sbaddress_write_valid_i) begin
            sbaddress_d = sbaddress_i;
        end

        if (!dmactive_i) begin
            sbaddress_d     = '0;
            sbdata_valid_d  = 1'b0;
            sberror_valid_d = 1'b0;
        end
    end

    // Bus request outputs, driven only while a request is pending.
    always_comb begin
        master_req_o   = 1'b0;
        master_we_o    = 1'b0;
        master_add_o   = '0;
        master_be_o    = '0;
        master_wdata_o = '0;
        if (state_q == SbaRead || state_q == SbaWrite) begin
            master_req_o = 1'b1;
            master_we_o  = (state_q == SbaWrite);
            master_add_o = {acc_addr_q[BusWidth-1:OffW], {OffW{1'b0}}};
            master_be_o  = al_be;
            if (state_q == SbaWrite) begin
                master_wdata_o = al_wdata;
            end
        end
    end

    assign sbbusy_o        = (state_q != SbaIdle);
    assign sbaddress_o     = sbaddress_q;
    assign sbdata_o        = sbdata_q;
    assign sbdata_valid_o  = sbdata_valid_q;
    assign sberror_o       = sberror_q;
    assign sberror_valid_o = sberror_valid_q;

endmodule

// File: tb/tb_dm_sba_serv.sv
// Directed bench for dm_sba_serv: a 32-bit instance for write vectors and
// corner sequences, a 64-bit instance for wide read lane extraction.
module tb_dm_sba_serv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, dmactive;

    // 32-bit instance signals
    logic [31:0] n_sbaddress, n_sbdata, n_rdata;
    logic        n_addr_wv, n_readonaddr, n_autoinc, n_readondata, n_data_wv, n_data_rv;
    logic [2:0]  n_access;
    logic        n_gnt, n_rvalid, n_rerr;
    logic [31:0] n_sbaddress_o, n_sbdata_o, n_add, n_wdata;
    logic        n_sbdata_valid, n_busy, n_err_valid, n_req, n_we;
    logic [2:0]  n_err;
    logic [3:0]  n_be;

    // 64-bit instance signals
    logic [63:0] w_sbaddress, w_sbdata, w_rdata;
    logic        w_addr_wv, w_readonaddr, w_autoinc, w_readondata, w_data_wv, w_data_rv;
    logic [2:0]  w_access;
    logic        w_gnt, w_rvalid, w_rerr;
    logic [63:0] w_sbaddress_o, w_sbdata_o, w_add, w_wdata;
    logic        w_sbdata_valid, w_busy, w_err_valid, w_req, w_we;
    logic [2:0]  w_err;
    logic [7:0]  w_be;

    dm_sba_serv #(.BusWidth(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
        .sbaddress_i(n_sbaddress), .sbaddress_write_valid_i(n_addr_wv),
        .sbreadonaddr_i(n_readonaddr), .sbautoincrement_i(n_autoinc),
        .sbaccess_i(n_access), .sbreadondata_i(n_readondata),
        .sbdata_i(n_sbdata), .sbdata_write_valid_i(n_data_wv),
        .sbdata_read_valid_i(n_data_rv),
        .sbaddress_o(n_sbaddress_o), .sbdata_o(n_sbdata_o),
        .sbdata_valid_o(n_sbdata_valid), .sbbusy_o(n_busy),
        .sberror_valid_o(n_err_valid), .sberror_o(n_err),
        .master_req_o(n_req), .master_add_o(n_add), .master_we_o(n_we),
        .master_wdata_o(n_wdata), .master_be_o(n_be),
        .master_gnt_i(n_gnt), .master_r_valid_i(n_rvalid),
        .master_r_rdata_i(n_rdata), .master_r_err_i(n_rerr)
    );

    dm_sba_serv #(.BusWidth(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
        .sbaddress_i(w_sbaddress), .sbaddress_write_valid_i(w_addr_wv),
        .sbreadonaddr_i(w_readonaddr), .sbautoincrement_i(w_autoinc),
        .sbaccess_i(w_access), .sbreadondata_i(w_readondata),
        .sbdata_i(w_sbdata), .sbdata_write_valid_i(w_data_wv),
        .sbdata_read_valid_i(w_data_rv),
        .sbaddress_o(w_sbaddress_o), .sbdata_o(w_sbdata_o),
        .sbdata_valid_o(w_sbdata_valid), .sbbusy_o(w_busy),
        .sberror_valid_o(w_err_valid), .sberror_o(w_err),
        .master_req_o(w_req), .master_add_o(w_add), .master_we_o(w_we),
        .master_wdata_o(w_wdata), .master_be_o(w_be),
        .master_gnt_i(w_gnt), .master_r_valid_i(w_rvalid),
        .master_r_rdata_i(w_rdata), .master_r_err_i(w_rerr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  access;
        logic [31:0] data;
        logic        err;
        logic [2:0]  code;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] add;
    } wvec_t;

    wvec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a[4];
        logic [31:0] nxt;

        vecs[0] = '{32'h0000_1002, 3'd1, 32'h0000_BEEF, 1'b0, 3'd0, 4'hC, 32'hBEEF_0000, 32'h0000_1000};
        vecs[1] = '{32'h0000_1000, 3'd2, 32'h1234_5678, 1'b0, 3'd0, 4'hF, 32'h1234_5678, 32'h0000_1000};
        vecs[2] = '{32'h0000_2003, 3'd0, 32'h0000_00A5, 1'b0, 3'd0, 4'h8, 32'hA500_0000, 32'h0000_2000};
        vecs[3] = '{32'h0000_1001, 3'd2, 32'h0000_0000, 1'b1, 3'd3, 4'h0, 32'h0,         32'h0};
        vecs[4] = '{32'h0000_1000, 3'd3, 32'h0000_0000, 1'b1, 3'd4, 4'h0, 32'h0,         32'h0};
        vecs[5] = '{32'h0000_1001, 3'd1, 32'h0000_0000, 1'b1, 3'd3, 4'h0, 32'h0,         32'h0};
        vecs[6] = '{32'h0000_0004, 3'd7, 32'h0000_0000, 1'b1, 3'd4, 4'h0, 32'h0,         32'h0};
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        rst = 1'b1; dmactive = 1'b1;
        n_sbaddress = '0; n_sbdata = '0; n_rdata = '0; n_addr_wv = 0; n_readonaddr = 0;
        n_autoinc = 0; n_readondata = 0; n_data_wv = 0; n_data_rv = 0; n_access = '0;
        n_gnt = 0; n_rvalid = 0; n_rerr = 0;
        w_sbaddress = '0; w_sbdata = '0; w_rdata = '0; w_addr_wv = 0; w_readonaddr = 0;
        w_autoinc = 0; w_readondata = 0; w_data_wv = 0; w_data_rv = 0; w_access = '0;
        w_gnt = 0; w_rvalid = 0; w_rerr = 0;
        tick(); tick();

        // Reset state
        chk("rst_sbaddress", n_sbaddress_o, 0);
        chk("rst_sbdata", n_sbdata_o, 0);
        chk("rst_sberror", n_err, 0);
        chk("rst_pulses", {n_sbdata_valid, n_err_valid}, 0);
        chk("rst_busy", n_busy, 0);
        chk("rst_master", {n_req, n_we, n_be, n_add, n_wdata}, 0);
        chk("rst_w_master", {w_req, w_we, w_be}, 0);
        rst = 1'b0;
        tick();

        // Table-driven write triggers
        for (int i = 0; i < 7; i++) begin
            n_sbaddress = vecs[i].addr; n_addr_wv = 1; n_readonaddr = 0;
            tick();
            n_addr_wv = 0;
            chk($sformatf("v%0d_addr_load", i), n_sbaddress_o, vecs[i].addr);
            n_access = vecs[i].access; n_sbdata = vecs[i].data; n_data_wv = 1;
            tick();
            n_data_wv = 0;
            if (vecs[i].err) begin
                chk($sformatf("v%0d_err_valid", i), n_err_valid, 1);
                chk($sformatf("v%0d_err_code", i), n_err, vecs[i].code);
                chk($sformatf("v%0d_no_req", i), {n_req, n_busy}, 0);
                tick();
                chk($sformatf("v%0d_err_pulse_end", i), n_err_valid, 0);
            end else begin
                chk($sformatf("v%0d_req_we", i), {n_req, n_we}, 2'b11);
                chk($sformatf("v%0d_be", i), n_be, vecs[i].be);
                chk($sformatf("v%0d_wdata", i), n_wdata, vecs[i].wdata);
                chk($sformatf("v%0d_add", i), n_add, vecs[i].add);
                n_gnt = 1;
                tick();
                n_gnt = 0;
                chk($sformatf("v%0d_wait", i), {n_req, n_busy}, 2'b01);
                n_rvalid = 1;
                tick();
                n_rvalid = 0;
                chk($sformatf("v%0d_done", i), {n_busy, n_err_valid, n_sbdata_valid}, 0);
            end
        end

        // Read-on-data with autoincrement across the address wrap
        n_sbaddress = 32'hFFFF_FFF8; n_addr_wv = 1; n_readonaddr = 0;
        tick();
        n_addr_wv = 0;
        n_readondata = 1; n_autoinc = 1; n_access = 3'd2;
        for (int i = 0; i < 4; i++) begin
            n_data_rv = 1;
            tick();
            n_data_rv = 0;
            chk($sformatf("ai%0d_add", i), n_add, exp_a[i]);
            chk($sformatf("ai%0d_req", i), {n_req, n_we}, 2'b10);
            n_gnt = 1;
            tick();
            n_gnt = 0;
            n_rvalid = 1; n_rdata = 32'hA000_0000 + i;
            tick();
            n_rvalid = 0;
            nxt = exp_a[i] + 32'd4;
            chk($sformatf("ai%0d_valid", i), n_sbdata_valid, 1);
            chk($sformatf("ai%0d_data", i), n_sbdata_o, 32'hA000_0000 + i);
            chk($sformatf("ai%0d_next_addr", i), n_sbaddress_o, nxt);
        end
        n_readondata = 0; n_autoinc = 0;

        // 64-bit read-on-address, minimum latency and upper-lane extraction
        w_sbaddress = 64'h2004; w_readonaddr = 1; w_access = 3'd2; w_addr_wv = 1;
        tick();
        w_addr_wv = 0; w_readonaddr = 0;
        chk("w_t1_req", {w_req, w_we}, 2'b10);
        chk("w_t1_add", w_add, 64'h2000);
        chk("w_t1_be", w_be, 8'hF0);
        w_gnt = 1;
        tick();
        w_gnt = 0;
        chk("w_t2_wait", {w_req, w_busy, w_sbdata_valid}, 3'b010);
        w_rvalid = 1; w_rdata = 64'h1122_3344_5566_7788;
        tick();
        w_rvalid = 0;
        chk("w_t3_valid", w_sbdata_valid, 1);
        chk("w_t3_data", w_sbdata_o, 64'h1122_3344);
        tick();
        chk("w_t4_pulse_end", {w_sbdata_valid, w_busy}, 0);

        // Grant withheld, dmactive dropped mid-request, stale response ignored
        n_sbaddress = 32'h3000; n_readonaddr = 1; n_access = 3'd2; n_addr_wv = 1;
        tick();
        n_addr_wv = 0; n_readonaddr = 0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("abort_c%0d_req", c), n_req, 1);
            if (c < 3) tick();
        end
        dmactive = 0;
        tick();
        chk("abort_req_low", {n_req, n_busy}, 0);
        chk("abort_sbaddress", n_sbaddress_o, 0);
        dmactive = 1;
        n_gnt = 1; n_rvalid = 1; n_rdata = 32'hDEAD_BEEF;
        tick();
        n_gnt = 0; n_rvalid = 0;
        tick();
        chk("abort_resp_ignored", {n_sbdata_valid, n_err_valid, n_busy}, 0);
        chk("abort_sbdata_kept", n_sbdata_o, 32'hA000_0003);

        // Address load while busy, then bus error response
        n_autoinc = 1; n_readonaddr = 1; n_access = 3'd2;
        n_sbaddress = 32'h4000; n_addr_wv = 1;
        tick();
        chk("busy_load_req", n_req, 1);
        chk("busy_load_add0", n_add, 32'h4000);
        n_sbaddress = 32'h5000;
        tick();
        n_addr_wv = 0; n_readonaddr = 0;
        chk("busy_load_sbaddress", n_sbaddress_o, 32'h5000);
        chk("busy_load_add_held", n_add, 32'h4000);
        n_gnt = 1;
        tick();
        n_gnt = 0;
        n_rvalid = 1; n_rerr = 1; n_rdata = 32'h1234_5678;
        tick();
        n_rvalid = 0; n_rerr = 0;
        chk("rerr_valid", n_err_valid, 1);
        chk("rerr_code", n_err, 3'd2);
        chk("rerr_no_data", n_sbdata_valid, 0);
        chk("rerr_sbdata_kept", n_sbdata_o, 32'hA000_0003);
        chk("rerr_no_inc", n_sbaddress_o, 32'h5000);
        chk("rerr_idle", n_busy, 0);
        n_autoinc = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
